// File: rtl/gpio_arb_pkg.sv
// Shared types and default sizing for the GPIO bank arbiter.
package gpio_arb_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int NPIN_DEF    = 34;
  localparam int QUANTUM_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    PARK  = 2'd2
  } arb_state_e;

  // Index of the set bit in a one-hot vector (0 when empty).
  function automatic int oh_to_idx(input logic [31:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++)
      if (oh[i]) idx = i;
    return idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority encoder: search starts one past the last owner.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_owner,
  output logic [NREQ-1:0] winner,
  output logic            valid
);

  // First requester at or after last_owner+1 (mod NREQ) wins.
  always_comb begin
    int idx;
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_owner) + k) % NREQ;
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_bank_arbiter.sv
// Time-shares one GPIO bank between NREQ requesters with a quantum and a
// one-cycle tri-stated handover (PARK) between owners.
module gpio_bank_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int NPIN    = NPIN_DEF,
  parameter int QUANTUM = QUANTUM_DEF
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 en,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*NPIN-1:0] req_out,
  input  logic [NREQ*NPIN-1:0] req_oeb,
  output logic [NREQ-1:0]      gnt,
  output logic [NPIN-1:0]      gpio_out,
  output logic [NPIN-1:0]      gpio_oeb,
  output logic                 busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int QW = $clog2(QUANTUM);
  localparam logic [QW-1:0] QMAX = QW'(QUANTUM - 1);
  localparam logic [IW-1:0] LO_RST = IW'(NREQ - 1);

  arb_state_e      state, state_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic [QW-1:0]   qcnt, qcnt_nxt;
  logic [IW-1:0]   last_owner, lo_nxt;
  logic [NREQ-1:0] pick;
  logic            pick_vld;
  logic            own_req, other_req;

  rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req        (req),
    .last_owner (last_owner),
    .winner     (pick),
    .valid      (pick_vld)
  );

  assign own_req   = |(req & gnt);
  assign other_req = |(req & ~gnt);
  assign busy      = (state != IDLE);

  // State, grant, quantum counter and rotation pointer registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= IDLE;
      gnt        <= '0;
      qcnt       <= '0;
      last_owner <= LO_RST;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      qcnt       <= qcnt_nxt;
      last_owner <= lo_nxt;
    end
  end

  // Next-state: arbitrate from IDLE/PARK, hold or hand over from GRANT.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    qcnt_nxt  = qcnt;
    lo_nxt    = last_owner;
    case (state)
      IDLE, PARK: begin
        if (en && pick_vld) begin
          state_nxt = GRANT;
          gnt_nxt   = pick;
          qcnt_nxt  = '0;
          // Record the owner at grant time so a disable mid-grant still
          // rotates past it on the next arbitration.
          lo_nxt    = IW'(oh_to_idx(32'(pick)));
        end else begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          qcnt_nxt  = '0;
        end
      end
      GRANT: begin
        // Release and quantum expiry share the same single PARK transition.
        if (!own_req || (qcnt == QMAX && other_req)) begin
          state_nxt = PARK;
          gnt_nxt   = '0;
          qcnt_nxt  = '0;
          lo_nxt    = IW'(oh_to_idx(32'(gnt)));
        end else begin
          qcnt_nxt  = (qcnt == QMAX) ? '0 : qcnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        qcnt_nxt  = '0;
      end
    endcase
    if (!en) begin
      state_nxt = IDLE;
      gnt_nxt   = '0;
      qcnt_nxt  = '0;
      lo_nxt    = last_owner;
    end
  end

  // Pin mux driven by the registered grant; no owner means all pins tri-stated.
  always_comb begin
    gpio_out = '0;
    gpio_oeb = '1;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gpio_out = req_out[i*NPIN +: NPIN];
        gpio_oeb = req_oeb[i*NPIN +: NPIN];
      end
    end
  end

endmodule
